// File: rtl/hd44780_ctrl.sv
// HD44780 character LCD controller: power-on init, then mirrors a ROWS x COLS
// character buffer onto the display whenever the buffer has been written.
module hd44780_ctrl #(
  parameter int CLK_HZ = 50_000_000,
  parameter int COLS   = 16,
  parameter int ROWS   = 2,
  parameter bit BUS4   = 1'b0,
  parameter int AW     = $clog2(ROWS * COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_char,
  output logic          busy,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic          lcd_en,
  output logic [7:0]    lcd_data
);
  localparam int US      = CLK_HZ / 1_000_000;
  localparam int NCHARS  = ROWS * COLS;
  localparam int PWR_CYC = 15000 * US;
  localparam int EN_RAW  = (CLK_HZ + 1_999_999) / 2_000_000;
  localparam int EN_CYC  = (EN_RAW < 1) ? 1 : EN_RAW;
  localparam int CW      = $clog2(PWR_CYC + 1);
  localparam int INIT_N  = BUS4 ? 8 : 7;

  typedef enum logic [1:0] {PWR_WAIT, INIT, IDLE, REFRESH} state_t;
  typedef enum logic [2:0] {XF_IDLE, XF_SETUP, XF_EN, XF_HOLD, XF_WAIT} phase_t;

  state_t        state;
  phase_t        phase;
  logic [CW-1:0] cnt;
  logic [CW-1:0] xf_wait;
  logic [3:0]    xf_nib_lo;
  logic          xf_pair;
  logic          xf_lo;
  logic [3:0]    step;
  logic [2:0]    row;
  logic [5:0]    col;
  logic          on_cmd;
  logic          dirty;
  logic [7:0]    buf_mem [NCHARS];
  logic [AW-1:0] rd_addr;
  logic          wr_ok;

  logic          go;
  logic [7:0]    go_byte;
  logic          go_rs;
  logic          go_single;
  logic [CW-1:0] go_wait;

  assign lcd_rw  = 1'b0;
  assign wr_ok   = wr_en && (int'(wr_addr) < NCHARS);
  assign rd_addr = AW'(int'(row) * COLS + int'(col));

  function automatic logic [7:0] init_byte(input logic [3:0] i);
    case (i)
      4'd0, 4'd1, 4'd2: init_byte = 8'h30;
      4'd3:             init_byte = BUS4 ? 8'h20 : 8'h38;
      4'd4:             init_byte = BUS4 ? 8'h28 : 8'h0C;
      4'd5:             init_byte = BUS4 ? 8'h0C : 8'h01;
      4'd6:             init_byte = BUS4 ? 8'h01 : 8'h06;
      default:          init_byte = 8'h06;
    endcase
  endfunction

  function automatic logic [CW-1:0] init_wait(input logic [3:0] i);
    case (i)
      4'd0:    init_wait = CW'(4100 * US);
      4'd1:    init_wait = CW'(100 * US);
      4'd5:    init_wait = BUS4 ? CW'(40 * US) : CW'(1640 * US);
      4'd6:    init_wait = BUS4 ? CW'(1640 * US) : CW'(40 * US);
      default: init_wait = CW'(40 * US);
    endcase
  endfunction

  function automatic logic [7:0] row_off(input logic [2:0] r);
    case (r)
      3'd0:    row_off = 8'h00;
      3'd1:    row_off = 8'h40;
      3'd2:    row_off = 8'h14;
      default: row_off = 8'h54;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCHARS; i++) buf_mem[i] <= 8'h20;
    end else if (wr_ok) begin
      buf_mem[wr_addr] <= wr_char;
    end
  end

  // Next transfer request, evaluated only while the strobe engine is idle.
  always_comb begin
    go        = 1'b0;
    go_byte   = 8'h00;
    go_rs     = 1'b0;
    go_single = 1'b0;
    go_wait   = CW'(40 * US);
    if (phase == XF_IDLE) begin
      case (state)
        INIT: if (int'(step) < INIT_N) begin
          go        = 1'b1;
          go_byte   = init_byte(step);
          go_single = BUS4 && (step < 4'd4);
          go_wait   = init_wait(step);
        end
        REFRESH: if (int'(row) < ROWS) begin
          go      = 1'b1;
          go_rs   = !on_cmd;
          go_byte = on_cmd ? (8'h80 | row_off(row)) : buf_mem[rd_addr];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PWR_WAIT;
      phase     <= XF_IDLE;
      cnt       <= '0;
      xf_wait   <= '0;
      xf_nib_lo <= '0;
      xf_pair   <= 1'b0;
      xf_lo     <= 1'b0;
      step      <= '0;
      row       <= '0;
      col       <= '0;
      on_cmd    <= 1'b0;
      dirty     <= 1'b0;
      busy      <= 1'b1;
      lcd_rs    <= 1'b0;
      lcd_en    <= 1'b0;
      lcd_data  <= 8'h00;
    end else begin
      // Strobe engine: setup 2, enable EN_CYC, hold 2, then execute wait.
      case (phase)
        XF_IDLE: if (go) begin
          phase     <= XF_SETUP;
          cnt       <= '0;
          xf_nib_lo <= go_byte[3:0];
          xf_pair   <= BUS4 && !go_single;
          xf_lo     <= 1'b0;
          xf_wait   <= go_wait;
          lcd_rs    <= go_rs;
          lcd_data  <= BUS4 ? {go_byte[7:4], 4'h0} : go_byte;
        end
        XF_SETUP: if (cnt == CW'(1)) begin
          cnt    <= '0;
          lcd_en <= 1'b1;
          phase  <= XF_EN;
        end else cnt <= cnt + CW'(1);
        XF_EN: if (cnt == CW'(EN_CYC - 1)) begin
          cnt    <= '0;
          lcd_en <= 1'b0;
          phase  <= XF_HOLD;
        end else cnt <= cnt + CW'(1);
        XF_HOLD: if (cnt == CW'(1)) begin
          cnt <= '0;
          if (xf_pair && !xf_lo) begin
            xf_lo    <= 1'b1;
            lcd_data <= {xf_nib_lo, 4'h0};
            phase    <= XF_SETUP;
          end else begin
            lcd_data <= 8'h00;
            phase    <= XF_WAIT;
          end
        end else cnt <= cnt + CW'(1);
        XF_WAIT: if (cnt == xf_wait - CW'(1)) begin
          cnt   <= '0;
          phase <= XF_IDLE;
        end else cnt <= cnt + CW'(1);
        default: phase <= XF_IDLE;
      endcase

      case (state)
        PWR_WAIT: if (cnt == CW'(PWR_CYC - 1)) begin
          cnt   <= '0;
          step  <= '0;
          state <= INIT;
        end else cnt <= cnt + CW'(1);
        INIT: if (phase == XF_IDLE) begin
          if (go) step <= step + 4'd1;
          else begin
            state <= IDLE;
            busy  <= 1'b0;
            dirty <= 1'b1;
          end
        end
        IDLE: if (dirty) begin
          state  <= REFRESH;
          busy   <= 1'b1;
          dirty  <= 1'b0;
          row    <= '0;
          col    <= '0;
          on_cmd <= 1'b1;
        end
        REFRESH: if (phase == XF_IDLE) begin
          if (go) begin
            if (on_cmd) on_cmd <= 1'b0;
            else if (col == 6'(COLS - 1)) begin
              col    <= '0;
              row    <= row + 3'd1;
              on_cmd <= 1'b1;
            end else col <= col + 6'd1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= PWR_WAIT;
      endcase

      // A write landing on the refresh-start cycle keeps the buffer dirty.
      if (wr_ok) dirty <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hd44780_ctrl.sv
// Bench for hd44780_ctrl: three instances (8-bit 2x16, 4-bit 2x16, 8-bit 4x20)
// whose captured LCD transfers are scored against bench-built expected queues.
`timescale 1ns/1ps
module tb_hd44780_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic       wr_en_a = 1'b0, wr_en_b = 1'b0, wr_en_c = 1'b0;
  logic [4:0] wr_addr_a = '0, wr_addr_b = '0;
  logic [6:0] wr_addr_c = '0;
  logic [7:0] wr_char_a = '0, wr_char_b = '0, wr_char_c = '0;
  logic       busy_a, rs_a, rw_a, en_a;
  logic       busy_b, rs_b, rw_b, en_b;
  logic       busy_c, rs_c, rw_c, en_c;
  logic [7:0] data_a, data_b, data_c;

  hd44780_ctrl #(.CLK_HZ(1_000_000), .COLS(16), .ROWS(2), .BUS4(1'b0)) u_a (
    .clk(clk), .rst(rst_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_char(wr_char_a),
    .busy(busy_a), .lcd_rs(rs_a), .lcd_rw(rw_a), .lcd_en(en_a), .lcd_data(data_a));
  hd44780_ctrl #(.CLK_HZ(1_000_000), .COLS(16), .ROWS(2), .BUS4(1'b1)) u_b (
    .clk(clk), .rst(rst_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_char(wr_char_b),
    .busy(busy_b), .lcd_rs(rs_b), .lcd_rw(rw_b), .lcd_en(en_b), .lcd_data(data_b));
  hd44780_ctrl #(.CLK_HZ(1_000_000), .COLS(20), .ROWS(4), .BUS4(1'b0)) u_c (
    .clk(clk), .rst(rst_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_char(wr_char_c),
    .busy(busy_c), .lcd_rs(rs_c), .lcd_rw(rw_c), .lcd_en(en_c), .lcd_data(data_c));

  // {rs, lcd_data} expected at each lcd_en rising edge.
  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  logic [8:0] exp_q2[$];
  logic [7:0] mdl [3][80];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic busy_of(input int which);
    case (which)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic [7:0] row_cmd(input int r);
    case (r)
      0:       return 8'h80;
      1:       return 8'hC0;
      2:       return 8'h94;
      default: return 8'hD4;
    endcase
  endfunction

  task automatic push_word(input int which, input logic [8:0] w);
    case (which)
      0:       exp_q0.push_back(w);
      1:       exp_q1.push_back(w);
      default: exp_q2.push_back(w);
    endcase
  endtask

  task automatic push_byte(input int which, input logic rs, input logic [7:0] b);
    if (which == 1) begin
      push_word(which, {rs, b[7:4], 4'h0});
      push_word(which, {rs, b[3:0], 4'h0});
    end else push_word(which, {rs, b});
  endtask

  task automatic push_init(input int which);
    if (which == 1) begin
      push_word(1, 9'h030); push_word(1, 9'h030); push_word(1, 9'h030); push_word(1, 9'h020);
      push_byte(1, 1'b0, 8'h28); push_byte(1, 1'b0, 8'h0C);
      push_byte(1, 1'b0, 8'h01); push_byte(1, 1'b0, 8'h06);
    end else begin
      push_byte(which, 1'b0, 8'h30); push_byte(which, 1'b0, 8'h30); push_byte(which, 1'b0, 8'h30);
      push_byte(which, 1'b0, 8'h38); push_byte(which, 1'b0, 8'h0C);
      push_byte(which, 1'b0, 8'h01); push_byte(which, 1'b0, 8'h06);
    end
  endtask

  task automatic push_refresh(input int which);
    int rows;
    int cols;
    rows = (which == 2) ? 4 : 2;
    cols = (which == 2) ? 20 : 16;
    for (int r = 0; r < rows; r++) begin
      push_byte(which, 1'b0, row_cmd(r));
      for (int c = 0; c < cols; c++) push_byte(which, 1'b1, mdl[which][r * cols + c]);
    end
  endtask

  task automatic sb_pop(input int which, input logic [8:0] got);
    logic [8:0] e;
    int n;
    n = qsize(which);
    check($sformatf("xfer_expected%0d", which), n != 0, 1);
    if (n != 0) begin
      case (which)
        0:       e = exp_q0.pop_front();
        1:       e = exp_q1.pop_front();
        default: e = exp_q2.pop_front();
      endcase
      check($sformatf("xfer%0d", which), got, e);
    end
  endtask

  task automatic wait_done(input int which, input int budget, input string tag);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = (qsize(which) == 0) && !busy_of(which);
    end
    check(tag, done, 1);
  endtask

  task automatic wr_a(input logic [4:0] addr, input logic [7:0] ch);
    @(negedge clk);
    wr_en_a = 1'b1; wr_addr_a = addr; wr_char_a = ch;
    @(negedge clk);
    wr_en_a = 1'b0;
    mdl[0][addr] = ch;
  endtask

  task automatic wr_c(input logic [6:0] addr, input logic [7:0] ch);
    @(negedge clk);
    wr_en_c = 1'b1; wr_addr_c = addr; wr_char_c = ch;
    @(negedge clk);
    wr_en_c = 1'b0;
    if (addr < 7'd80) mdl[2][addr] = ch;
  endtask

  // Monitors: capture {rs, data} on each lcd_en rise, sampled on the falling clock edge.
  logic       en_a_q = 1'b0, en_b_q = 1'b0, en_c_q = 1'b0;
  int         cyc_a = 0, first_a = -1, gap01_a = -1, last_rise_a = 0;
  logic [8:0] last_w_a = '0;

  always @(negedge clk) begin
    if (rst_a) begin
      cyc_a = 0; first_a = -1; gap01_a = -1; last_w_a = '0;
    end else begin
      cyc_a++;
      if (en_a && !en_a_q) begin
        if (first_a < 0) first_a = cyc_a;
        if (last_w_a == 9'h001) gap01_a = cyc_a - last_rise_a;
        last_rise_a = cyc_a;
        last_w_a = {rs_a, data_a};
        sb_pop(0, {rs_a, data_a});
      end
    end
    en_a_q = en_a;
  end

  always @(negedge clk) begin
    if (en_b && !en_b_q) sb_pop(1, {rs_b, data_b});
    en_b_q = en_b;
  end

  always @(negedge clk) begin
    if (en_c && !en_c_q) sb_pop(2, {rs_c, data_c});
    en_c_q = en_c;
  end

  initial begin
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 80; i++) mdl[k][i] = 8'h20;
    fork
      begin : thr_a
        int n;
        repeat (3) @(negedge clk);
        check("a_rst_en", en_a, 0);
        check("a_rst_data", data_a, 8'h00);
        check("a_rst_rs", rs_a, 0);
        check("a_rst_rw", rw_a, 0);
        check("a_rst_busy", busy_a, 1);
        push_init(0); push_refresh(0);
        rst_a = 1'b0;
        wait_done(0, 30000, "a_init_done");
        check("a_first_en_late", first_a >= 15000, 1);
        check("a_gap_after_clear", gap01_a >= 1640, 1);

        repeat (5) @(negedge clk);
        check("a_idle_busy", busy_a, 0);
        wr_a(5'd17, 8'h41);
        push_refresh(0);
        @(negedge clk);
        check("a_busy_rise", busy_a, 1);
        wait_done(0, 5000, "a_refresh17");

        wr_a(5'd5, 8'h43);
        push_refresh(0);
        n = 0;
        while (exp_q0.size() > 16 && n < 5000) begin
          @(negedge clk);
          n++;
        end
        check("a_row1_reached", exp_q0.size() <= 16, 1);
        wr_a(5'd0, 8'h42);
        push_refresh(0);
        wait_done(0, 8000, "a_two_pass");
        repeat (300) @(negedge clk);
        check("a_quiet", busy_a, 0);

        wr_a(5'd31, 8'h44);
        push_refresh(0);
        n = 0;
        while (!en_a && n < 500) begin
          @(negedge clk);
          n++;
        end
        check("a_en_seen", en_a, 1);
        #2 rst_a = 1'b1;
        #1;
        check("a_async_en", en_a, 0);
        check("a_async_data", data_a, 8'h00);
        check("a_async_busy", busy_a, 1);
        exp_q0.delete();
        for (int i = 0; i < 80; i++) mdl[0][i] = 8'h20;
        push_init(0); push_refresh(0);
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        wait_done(0, 30000, "a_reinit_done");
        check("a_re_first_en_late", first_a >= 15000, 1);
        check("a_re_gap_after_clear", gap01_a >= 1640, 1);
      end
      begin : thr_b
        repeat (3) @(negedge clk);
        check("b_rst_en", en_b, 0);
        check("b_rst_data", data_b, 8'h00);
        check("b_rst_busy", busy_b, 1);
        push_init(1); push_refresh(1);
        rst_b = 1'b0;
        wait_done(1, 30000, "b_init_done");
      end
      begin : thr_c
        repeat (3) @(negedge clk);
        check("c_rst_en", en_c, 0);
        check("c_rst_busy", busy_c, 1);
        push_init(2); push_refresh(2);
        rst_c = 1'b0;
        wait_done(2, 35000, "c_init_done");
        wr_c(7'd100, 8'h55);
        repeat (200) @(negedge clk);
        check("c_oob_busy", busy_c, 0);
        wr_c(7'd79, 8'h5A);
        push_refresh(2);
        wait_done(2, 6000, "c_refresh79");
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
